mem_stage: RTL

- MEM stage of the 5-stage RISC-V pipeline. It is the consumer end of the EX/MEM pipeline register.
- Takes the registered ALU result, destination register, store data, control and func3, and performs byte/half/word loads and stores on an internal word-organised data memory.
- Sign- or zero-extends load data, then registers results into the MEM/WB boundary for write-back.
- Detects misaligned and illegal accesses, suppresses their side effects, and counts them.

---
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB pipeline boundary bundle for the MEM stage.
// master = upstream EX stage / driver, slave = mem_stage.
interface mem_stage_if;
  logic [31:0] alu_out_EX_MEM;
  logic [4:0]  rd_EX_MEM;
  logic [31:0] imm_data_EX_MEM;
  logic [3:0]  control_EX_MEM;
  logic [2:0]  func3_EX_MEM;

  logic [31:0] read_data_MEM_WB;
  logic [31:0] alu_out_MEM_WB;
  logic [4:0]  rd_MEM_WB;
  logic [1:0]  control_MEM_WB;
  logic        fault_MEM_WB;

  modport master (
    output alu_out_EX_MEM, rd_EX_MEM, imm_data_EX_MEM, control_EX_MEM, func3_EX_MEM,
    input  read_data_MEM_WB, alu_out_MEM_WB, rd_MEM_WB, control_MEM_WB, fault_MEM_WB
  );

  modport slave (
    input  alu_out_EX_MEM, rd_EX_MEM, imm_data_EX_MEM, control_EX_MEM, func3_EX_MEM,
    output read_data_MEM_WB, alu_out_MEM_WB, rd_MEM_WB, control_MEM_WB, fault_MEM_WB
  );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: byte/half/word loads and stores on an internal word memory,
// fault detection with a saturating counter, registered MEM/WB outputs.
module mem_stage #(
  parameter int ADDR_BITS   = 8,
  parameter int FAULT_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_stage_if.slave             bus,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic [2:0]           func3;
  logic [1:0]           off;
  logic [ADDR_BITS-1:0] idx;

  assign mem_read   = bus.control_EX_MEM[0];
  assign mem_write  = bus.control_EX_MEM[1];
  assign reg_write  = bus.control_EX_MEM[2];
  assign mem_to_reg = bus.control_EX_MEM[3];
  assign func3      = bus.func3_EX_MEM;
  assign off        = bus.alu_out_EX_MEM[1:0];
  assign idx        = bus.alu_out_EX_MEM[ADDR_BITS+1:2];

  logic        active;
  logic        illegal;
  logic        misaligned;
  logic        fault;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [31:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    active     = mem_read | mem_write;
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (active) begin
      illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111)
             || (mem_write && ((func3 == 3'b100) || (func3 == 3'b101)))
             || (mem_read && mem_write);
      misaligned = (((func3 == 3'b001) || (func3 == 3'b101)) && off[0])
                || ((func3 == 3'b010) && (off != 2'b00));
    end
    fault = illegal | misaligned;
  end

  // Store lane steering: data is replicated across lanes, byte enables pick the target.
  always_comb begin
    we    = mem_write & ~fault;
    be    = '0;
    wdata = bus.imm_data_EX_MEM;
    case (func3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{bus.imm_data_EX_MEM[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.imm_data_EX_MEM[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rword    = mem[idx];
    shifted  = rword >> {off, 3'b000};
    load_val = '0;
    case (func3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = rword;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_data_MEM_WB <= '0;
      bus.alu_out_MEM_WB   <= '0;
      bus.rd_MEM_WB        <= '0;
      bus.control_MEM_WB   <= '0;
      bus.fault_MEM_WB     <= 1'b0;
      fault_count          <= '0;
    end else begin
      bus.read_data_MEM_WB <= (mem_read && !fault) ? load_val : '0;
      bus.alu_out_MEM_WB   <= bus.alu_out_EX_MEM;
      bus.rd_MEM_WB        <= bus.rd_EX_MEM;
      bus.control_MEM_WB   <= {mem_to_reg, reg_write & ~fault};
      bus.fault_MEM_WB     <= fault;
      if (fault && (fault_count != '1)) fault_count <= fault_count + 1'b1;
    end
  end

endmodule
